// File: rtl/veggie_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// veggie_pkg : shared state type, frame constants and abs-diff helper
// Rev 1.0
// ---------------------------------------------------------------------------
package veggie_pkg;

   localparam int SCREEN_W = 1024;
   localparam int SCREEN_H = 768;

   // The frame strobe sits at the first pixel past the visible area.
   localparam logic [10:0] FRAME_H_DONE = 11'(SCREEN_W);
   localparam logic [9:0]  FRAME_V_DONE = 10'(SCREEN_H);

   typedef enum logic [1:0] {
      ARMING = 2'd0,
      WHOLE  = 2'd1,
      SPLIT  = 2'd2
   } slice_state_t;

   function automatic logic [11:0] abs_diff12(input logic [11:0] a, input logic [11:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage
`default_nettype wire

// File: rtl/blade_speed.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// blade_speed : previous blade sample and per-frame Manhattan travel
// Rev 1.0
// ---------------------------------------------------------------------------
module blade_speed
   import veggie_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in_n,
   input  logic        i_frame_done,
   input  logic [10:0] i_blade_x,
   input  logic [9:0]  i_blade_y,
   input  logic        i_blade_valid,
   output logic [11:0] o_speed,
   output logic        o_prev_valid
);

   logic [10:0] r_prev_x;
   logic [9:0]  r_prev_y;
   logic        r_prev_valid;

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_prev_x     <= '0;
         r_prev_y     <= '0;
         r_prev_valid <= 1'b0;
      end else if (i_frame_done) begin
         r_prev_x     <= i_blade_x;
         r_prev_y     <= i_blade_y;
         r_prev_valid <= i_blade_valid;
      end
   end

   // Speed uses the samples from the previous strobe, before this strobe updates them.
   assign o_speed      = abs_diff12({1'b0, i_blade_x}, {1'b0, r_prev_x})
                       + abs_diff12({2'b0, i_blade_y}, {2'b0, r_prev_y});
   assign o_prev_valid = r_prev_valid;

endmodule
`default_nettype wire

// File: rtl/slice_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// slice_detector : once-per-frame blade/fruit slice decision, score and combo
// Rev 1.0
// ---------------------------------------------------------------------------
module slice_detector
   import veggie_pkg::*;
#(
   parameter int HIT_RADIUS   = 32,
   parameter int MIN_SWIPE    = 8,
   parameter int ARM_FRAMES   = 6,
   parameter int COMBO_WINDOW = 30,
   parameter int SCORE_W      = 12
) (
   input  logic               clk_in,
   input  logic               rst_in_n,
   input  logic [10:0]        hcount,
   input  logic [9:0]         vcount,
   input  logic [10:0]        fruit_x,
   input  logic [9:0]         fruit_y,
   input  logic               fruit_respawn,
   input  logic [10:0]        blade_x,
   input  logic [9:0]         blade_y,
   input  logic               blade_valid,
   output logic               split_out,
   output logic               split_pulse,
   output logic [10:0]        split_x,
   output logic [9:0]         split_y,
   output logic [2:0]         combo_out,
   output logic [SCORE_W-1:0] score_out
);

   localparam int ARM_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
   localparam int WIN_W = $clog2(COMBO_WINDOW + 1);

   localparam logic [ARM_W-1:0] C_ARM_LAST  = ARM_W'(ARM_FRAMES - 1);
   localparam logic [WIN_W-1:0] C_WIN_MAX   = WIN_W'(COMBO_WINDOW);
   localparam logic [11:0]      C_RADIUS    = 12'(HIT_RADIUS);
   localparam logic [11:0]      C_MIN_SWIPE = 12'(MIN_SWIPE);
   localparam logic [2:0]       C_COMBO_MAX = 3'd7;

   slice_state_t       r_state,    w_state_nxt;
   logic [ARM_W-1:0]   r_arm_cnt,  w_arm_nxt;
   logic [WIN_W-1:0]   r_win_cnt,  w_win_nxt;
   logic               r_split,    w_split_nxt;
   logic               r_pulse,    w_pulse_nxt;
   logic [10:0]        r_split_x,  w_split_x_nxt;
   logic [9:0]         r_split_y,  w_split_y_nxt;
   logic [2:0]         r_combo,    w_combo_nxt;
   logic [SCORE_W-1:0] r_score,    w_score_nxt;

   logic               w_frame_done;
   logic [11:0]        w_speed;
   logic               w_prev_valid;
   logic               w_swipe;
   logic               w_hit;
   logic [2:0]         w_combo_inc;
   logic [SCORE_W:0]   w_score_sum;

   assign w_frame_done = (hcount == FRAME_H_DONE) && (vcount == FRAME_V_DONE);

   blade_speed u_blade_speed (
      .clk_in        (clk_in),
      .rst_in_n      (rst_in_n),
      .i_frame_done  (w_frame_done),
      .i_blade_x     (blade_x),
      .i_blade_y     (blade_y),
      .i_blade_valid (blade_valid),
      .o_speed       (w_speed),
      .o_prev_valid  (w_prev_valid)
   );

   assign w_swipe = blade_valid && w_prev_valid && (w_speed >= C_MIN_SWIPE);
   assign w_hit   = (abs_diff12({1'b0, blade_x}, {1'b0, fruit_x}) < C_RADIUS)
                 && (abs_diff12({2'b0, blade_y}, {2'b0, fruit_y}) < C_RADIUS);

   assign w_combo_inc = (r_combo == C_COMBO_MAX) ? C_COMBO_MAX : (r_combo + 3'd1);
   assign w_score_sum = {1'b0, r_score} + {{(SCORE_W - 2){1'b0}}, w_combo_inc};

   always_comb begin
      w_state_nxt   = r_state;
      w_arm_nxt     = r_arm_cnt;
      w_win_nxt     = r_win_cnt;
      w_split_nxt   = r_split;
      w_pulse_nxt   = 1'b0;
      w_split_x_nxt = r_split_x;
      w_split_y_nxt = r_split_y;
      w_combo_nxt   = r_combo;
      w_score_nxt   = r_score;

      if (w_frame_done) begin
         if (r_win_cnt != C_WIN_MAX) begin
            w_win_nxt = r_win_cnt + 1'b1;
         end
         if (w_win_nxt == C_WIN_MAX) begin
            w_combo_nxt = 3'd0;
         end

         case (r_state)
            ARMING: begin
               w_arm_nxt = r_arm_cnt + 1'b1;
               if (r_arm_cnt == C_ARM_LAST) begin
                  w_state_nxt = WHOLE;
               end
            end
            WHOLE: begin
               // A respawn on the decision cycle cancels the slice outright.
               if (w_swipe && w_hit && !fruit_respawn) begin
                  w_state_nxt   = SPLIT;
                  w_pulse_nxt   = 1'b1;
                  w_split_nxt   = 1'b1;
                  w_split_x_nxt = fruit_x;
                  w_split_y_nxt = fruit_y;
                  w_combo_nxt   = w_combo_inc;
                  w_score_nxt   = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
                  w_win_nxt     = '0;
               end
            end
            SPLIT: begin
               w_state_nxt = SPLIT;
            end
            default: begin
               w_state_nxt = ARMING;
               w_arm_nxt   = '0;
            end
         endcase
      end

      if (fruit_respawn) begin
         w_state_nxt = ARMING;
         w_arm_nxt   = '0;
         w_split_nxt = 1'b0;
         // An unsliced fruit escaping breaks the combo.
         if (r_state == WHOLE) begin
            w_combo_nxt = 3'd0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_state   <= ARMING;
         r_arm_cnt <= '0;
         r_win_cnt <= C_WIN_MAX;
         r_split   <= 1'b0;
         r_pulse   <= 1'b0;
         r_split_x <= '0;
         r_split_y <= '0;
         r_combo   <= 3'd0;
         r_score   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_arm_cnt <= w_arm_nxt;
         r_win_cnt <= w_win_nxt;
         r_split   <= w_split_nxt;
         r_pulse   <= w_pulse_nxt;
         r_split_x <= w_split_x_nxt;
         r_split_y <= w_split_y_nxt;
         r_combo   <= w_combo_nxt;
         r_score   <= w_score_nxt;
      end
   end

   assign split_out   = r_split;
   assign split_pulse = r_pulse;
   assign split_x     = r_split_x;
   assign split_y     = r_split_y;
   assign combo_out   = r_combo;
   assign score_out   = r_score;

endmodule
`default_nettype wire
